// File: rtl/ccm_arb.sv
// ccm_arb: two-port (LSU, DMA) arbiter in front of a single-ported DCCM.
// Latency: grant and DCCM strobes are combinational; read response 1 cycle after acceptance.
// Backpressure: only the granted requester sees ready; responses cannot be stalled.
//
// Ports:
//   clk, rst_n                     - single clock, synchronous active-low reset
//   lsu_req_* / lsu_rsp_*          - LSU request (valid/ready/we/addr/wdata) and read response
//   dma_req_* / dma_rsp_*          - DMA request and read response, same meaning as LSU
//   dccm_wren/rden/wr_addr/wr_data - DCCM access strobes, shared address and write data
//   dccm_rd_data                   - DCCM read data, valid the cycle after dccm_rden
//
// Optional feature: define CCM_ARB_STARVE_GUARD_EN to enable the DMA anti-starvation
// counter. With it, DMA wins over LSU after STARVE_LIMIT consecutive blocked cycles.
// Without it, LSU has strict priority and STARVE_LIMIT has no effect.
module ccm_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_we,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_wdata,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rsp_rdata,

    input  logic        dma_req_valid,
    output logic        dma_req_ready,
    input  logic        dma_req_we,
    input  logic [31:0] dma_req_addr,
    input  logic [31:0] dma_req_wdata,
    output logic        dma_rsp_valid,
    output logic [31:0] dma_rsp_rdata,

    output logic        dccm_wren,
    output logic        dccm_rden,
    output logic [31:0] dccm_wr_addr,
    output logic [31:0] dccm_wr_data,
    input  logic [31:0] dccm_rd_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LSU  = 2'd1,
        OWN_DMA  = 2'd2
    } own_t;

    // The counter is 4 bits wide, so the limit must fit in 1..15.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_range
        $error("ccm_arb: STARVE_LIMIT must be in 1..15");
    end

    own_t rsp_own;
    logic dma_force;
    logic grant_lsu;
    logic grant_dma;

`ifdef CCM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    // Once DMA has been blocked for STARVE_LIMIT cycles it overrides LSU priority.
    assign dma_force = dma_req_valid && (starve_cnt == 4'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!dma_req_valid || grant_dma) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign dma_force = 1'b0;
`endif

    // Grants are suppressed while reset is asserted so no DCCM access leaks out.
    assign grant_lsu = rst_n && lsu_req_valid && !dma_force;
    assign grant_dma = rst_n && dma_req_valid && (!lsu_req_valid || dma_force);

    assign lsu_req_ready = grant_lsu;
    assign dma_req_ready = grant_dma;

    always_comb begin
        dccm_wren    = 1'b0;
        dccm_rden    = 1'b0;
        dccm_wr_addr = 32'd0;
        dccm_wr_data = 32'd0;
        if (grant_lsu) begin
            dccm_wren    = lsu_req_we;
            dccm_rden    = !lsu_req_we;
            dccm_wr_addr = lsu_req_addr;
            dccm_wr_data = lsu_req_wdata;
        end else if (grant_dma) begin
            dccm_wren    = dma_req_we;
            dccm_rden    = !dma_req_we;
            dccm_wr_addr = dma_req_addr;
            dccm_wr_data = dma_req_wdata;
        end
    end

    // Remember who owns the read data returning next cycle; writes produce no response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_own <= OWN_NONE;
        end else if (grant_lsu && !lsu_req_we) begin
            rsp_own <= OWN_LSU;
        end else if (grant_dma && !dma_req_we) begin
            rsp_own <= OWN_DMA;
        end else begin
            rsp_own <= OWN_NONE;
        end
    end

    // Qualified by rst_n so a read accepted just before reset never returns data.
    assign lsu_rsp_valid = rst_n && (rsp_own == OWN_LSU);
    assign dma_rsp_valid = rst_n && (rsp_own == OWN_DMA);
    assign lsu_rsp_rdata = lsu_rsp_valid ? dccm_rd_data : 32'd0;
    assign dma_rsp_rdata = dma_rsp_valid ? dccm_rd_data : 32'd0;

endmodule

// File: tb/tb_ccm_arb.sv
module tb_ccm_arb;

    logic        clk;
    logic        rst_n;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_we;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_rdata;
    logic        dma_req_valid, dma_req_ready, dma_req_we;
    logic [31:0] dma_req_addr, dma_req_wdata;
    logic        dma_rsp_valid;
    logic [31:0] dma_rsp_rdata;
    logic        dccm_wren, dccm_rden;
    logic [31:0] dccm_wr_addr, dccm_wr_data, dccm_rd_data;

    int checks = 0;
    int errors = 0;

    ccm_arb #(.STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .dma_req_valid (dma_req_valid),
        .dma_req_ready (dma_req_ready),
        .dma_req_we    (dma_req_we),
        .dma_req_addr  (dma_req_addr),
        .dma_req_wdata (dma_req_wdata),
        .dma_rsp_valid (dma_rsp_valid),
        .dma_rsp_rdata (dma_rsp_rdata),
        .dccm_wren     (dccm_wren),
        .dccm_rden     (dccm_rden),
        .dccm_wr_addr  (dccm_wr_addr),
        .dccm_wr_data  (dccm_wr_data),
        .dccm_rd_data  (dccm_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DCCM model: unwritten words read as {addr[15:0], 16'hC0DE}.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], 16'hC0DE};
    endfunction

    initial dccm_rd_data = 32'd0;
    always @(posedge clk) begin
        if (dccm_rden) dccm_rd_data <= mem_rd(dccm_wr_addr);
        if (dccm_wren) mem[dccm_wr_addr] = dccm_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        lsu_req_valid = 1'b0; lsu_req_we = 1'b0; lsu_req_addr = 32'd0; lsu_req_wdata = 32'd0;
        dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_addr = 32'd0; dma_req_wdata = 32'd0;
    endtask

    initial begin
        logic exp_dma;
        logic [31:0] a;
        idle_all();
        rst_n = 1'b0;
        // Requests during reset must not be granted.
        lsu_req_valid = 1'b1;
        dma_req_valid = 1'b1;
        @(negedge clk);
        chk("rst_lsu_ready", 32'(lsu_req_ready), 32'd0);
        chk("rst_dma_ready", 32'(dma_req_ready), 32'd0);
        chk("rst_rden", 32'(dccm_rden), 32'd0);
        chk("rst_wren", 32'(dccm_wren), 32'd0);
        step();
        idle_all();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
        chk("post_rst_dma_rsp_valid", 32'(dma_rsp_valid), 32'd0);
        chk("post_rst_lsu_rdata", lsu_rsp_rdata, 32'd0);
        chk("post_rst_addr", dccm_wr_addr, 32'd0);

        // LSU write then read of the same word.
        step();
        lsu_req_valid = 1'b1; lsu_req_we = 1'b1;
        lsu_req_addr = 32'h100; lsu_req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_ready", 32'(lsu_req_ready), 32'd1);
        chk("wr_wren", 32'(dccm_wren), 32'd1);
        chk("wr_rden", 32'(dccm_rden), 32'd0);
        chk("wr_addr", dccm_wr_addr, 32'h100);
        chk("wr_data", dccm_wr_data, 32'hDEADBEEF);
        step();
        lsu_req_we = 1'b0; lsu_req_wdata = 32'd0;
        @(negedge clk);
        chk("rd_wren", 32'(dccm_wren), 32'd0);
        chk("rd_rden", 32'(dccm_rden), 32'd1);
        chk("wr_no_rsp", 32'(lsu_rsp_valid), 32'd0);
        step();
        idle_all();
        @(negedge clk);
        chk("rd_rsp_valid", 32'(lsu_rsp_valid), 32'd1);
        chk("rd_rsp_data", lsu_rsp_rdata, 32'hDEADBEEF);
        chk("rd_dma_quiet", 32'(dma_rsp_valid), 32'd0);
        chk("rd_idle_rden", 32'(dccm_rden), 32'd0);

        // Simultaneous reads: LSU first, DMA next cycle.
        step();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h10;
        dma_req_valid = 1'b1; dma_req_addr = 32'h20;
        @(negedge clk);
        chk("both_lsu_ready", 32'(lsu_req_ready), 32'd1);
        chk("both_dma_ready", 32'(dma_req_ready), 32'd0);
        chk("both_addr0", dccm_wr_addr, 32'h10);
        step();
        lsu_req_valid = 1'b0; lsu_req_addr = 32'd0;
        @(negedge clk);
        chk("both_dma_ready2", 32'(dma_req_ready), 32'd1);
        chk("both_addr1", dccm_wr_addr, 32'h20);
        chk("both_lsu_rsp_v", 32'(lsu_rsp_valid), 32'd1);
        chk("both_lsu_rsp_d", lsu_rsp_rdata, 32'h0010C0DE);
        chk("both_dma_rsp_v0", 32'(dma_rsp_valid), 32'd0);
        step();
        idle_all();
        @(negedge clk);
        chk("both_dma_rsp_v", 32'(dma_rsp_valid), 32'd1);
        chk("both_dma_rsp_d", dma_rsp_rdata, 32'h0020C0DE);
        chk("both_lsu_rsp_v1", 32'(lsu_rsp_valid), 32'd0);
        chk("both_lsu_rsp_d1", lsu_rsp_rdata, 32'd0);

        // Continuous contention for 20 cycles.
        step();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h40;
        dma_req_valid = 1'b1; dma_req_addr = 32'h80;
        for (int i = 0; i < 20; i++) begin
            if (i != 0) step();
`ifdef CCM_ARB_STARVE_GUARD_EN
            exp_dma = ((i % 5) == 4);
`else
            exp_dma = 1'b0;
`endif
            @(negedge clk);
            chk($sformatf("starve_dma_ready_%0d", i), 32'(dma_req_ready), 32'(exp_dma));
            chk($sformatf("starve_lsu_ready_%0d", i), 32'(lsu_req_ready), 32'(!exp_dma));
        end
        step();
        idle_all();

        // Alternating single-owner reads, one per cycle.
        for (int i = 0; i < 8; i++) begin
            a = 32'h200 + 32'(i * 4);
            if (i % 2 == 0) begin
                lsu_req_valid = 1'b1; lsu_req_addr = a;
                dma_req_valid = 1'b0; dma_req_addr = 32'd0;
            end else begin
                dma_req_valid = 1'b1; dma_req_addr = a;
                lsu_req_valid = 1'b0; lsu_req_addr = 32'd0;
            end
            @(negedge clk);
            if (i % 2 == 0) chk($sformatf("alt_lsu_ready_%0d", i), 32'(lsu_req_ready), 32'd1);
            else            chk($sformatf("alt_dma_ready_%0d", i), 32'(dma_req_ready), 32'd1);
            if (i > 0) begin
                // Response for the read issued in cycle i-1.
                chk($sformatf("alt_lsu_v_%0d", i), 32'(lsu_rsp_valid), 32'((i - 1) % 2 == 0));
                chk($sformatf("alt_dma_v_%0d", i), 32'(dma_rsp_valid), 32'((i - 1) % 2 == 1));
                chk($sformatf("alt_data_%0d", i), lsu_rsp_rdata | dma_rsp_rdata,
                    {16'(32'h200 + 32'((i - 1) * 4)), 16'hC0DE});
            end
            step();
        end
        idle_all();
        @(negedge clk);
        chk("alt_last_dma_v", 32'(dma_rsp_valid), 32'd1);
        chk("alt_last_lsu_v", 32'(lsu_rsp_valid), 32'd0);
        chk("alt_last_data", dma_rsp_rdata, 32'h021CC0DE);

        // Read, write, read of one address: order follows acceptance.
        step();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h300;
        step();
        lsu_req_valid = 1'b0;
        dma_req_valid = 1'b1; dma_req_we = 1'b1;
        dma_req_addr = 32'h300; dma_req_wdata = 32'h12345678;
        @(negedge clk);
        chk("order_old_data", lsu_rsp_rdata, 32'h0300C0DE);
        chk("order_wr_no_rsp_pending", 32'(dccm_wren), 32'd1);
        step();
        idle_all();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h300;
        @(negedge clk);
        chk("order_wr_no_rsp", 32'(dma_rsp_valid), 32'd0);
        step();
        idle_all();
        @(negedge clk);
        chk("order_new_data", lsu_rsp_rdata, 32'h12345678);

        // DMA read immediately followed by reset: no response.
        step();
        dma_req_valid = 1'b1; dma_req_addr = 32'h44;
        @(negedge clk);
        chk("prerst_dma_ready", 32'(dma_req_ready), 32'd1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("inrst_dma_rsp_v", 32'(dma_rsp_valid), 32'd0);
        chk("inrst_dma_rsp_d", dma_rsp_rdata, 32'd0);
        chk("inrst_dma_ready", 32'(dma_req_ready), 32'd0);
        step();
        idle_all();
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_outputs",
            {26'd0, lsu_req_ready, dma_req_ready, lsu_rsp_valid, dma_rsp_valid, dccm_wren, dccm_rden},
            32'd0);
        chk("after_rst_rdata", lsu_rsp_rdata | dma_rsp_rdata | dccm_wr_addr | dccm_wr_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
